// File: rtl/ir_queue.sv
// ---------------------------------------------------------------------------
// ir_queue -- instruction queue between fetch and decode for an LC-3b core.
//
// A DEPTH-entry circular FIFO of {instruction word, PC} pairs. Fetch pushes
// with a valid/ready handshake; decode sees the head entry and pops it by
// raising out_ready. The head instruction is split into its LC-3b fields
// combinationally so decode can use them directly.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      synchronous active-low reset (pointers and count only)
//   flush        drop every held entry on the next edge (beats push/pop)
//   in_valid     fetch presents in_instr/in_pc
//   in_ready     queue has room (count < DEPTH)
//   in_instr     fetched instruction word
//   in_pc        PC of the fetched instruction
//   out_valid    head entry is valid (count != 0)
//   out_ready    decode consumes the head this cycle
//   out_instr    head instruction word (zero when empty)
//   out_pc       head PC (zero when empty)
//   opcode..trapvect  decoded fields of out_instr
//   count        number of valid entries
// ---------------------------------------------------------------------------
module ir_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_instr,
    input  logic [15:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_instr,
    output logic [15:0]                out_pc,
    output logic [3:0]                 opcode,
    output logic [2:0]                 dest,
    output logic [2:0]                 src1,
    output logic [2:0]                 src2,
    output logic [5:0]                 offset6,
    output logic [8:0]                 offset9,
    output logic [4:0]                 imm5,
    output logic                       imm_bool,
    output logic [10:0]                offset11,
    output logic                       jsr_bool,
    output logic [3:0]                 imm4,
    output logic                       shift_bool,
    output logic [7:0]                 trapvect,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Storage is never reset: stale contents are unreachable once the
    // pointers and count return to zero.
    logic [15:0]      instr_mem_q [DEPTH];
    logic [15:0]      pc_mem_q    [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic             pop;

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);

    // in_ready looks only at count, so a full queue refuses a push even
    // when a pop frees a slot on the same edge.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write port; gated by reset so a push during reset leaves no trace.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            instr_mem_q[tail_q] <= in_instr;
            pc_mem_q[tail_q]    <= in_pc;
        end
    end

    // Head is read straight from storage; a new entry is only visible after
    // count updates, so there is no same-cycle bypass from the inputs.
    assign out_instr = out_valid ? instr_mem_q[head_q] : 16'h0000;
    assign out_pc    = out_valid ? pc_mem_q[head_q]    : 16'h0000;
    assign count     = count_q;

    assign opcode     = out_instr[15:12];
    assign dest       = out_instr[11:9];
    assign src1       = out_instr[8:6];
    assign src2       = out_instr[2:0];
    assign offset6    = out_instr[5:0];
    assign offset9    = out_instr[8:0];
    assign imm5       = out_instr[4:0];
    assign imm_bool   = out_instr[5];
    assign offset11   = out_instr[10:0];
    assign jsr_bool   = out_instr[11];
    assign imm4       = out_instr[3:0];
    assign shift_bool = out_instr[4];
    assign trapvect   = out_instr[7:0];

endmodule

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of instruction entries held; legal values are powers of two from 2 to 16.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 Port flush  input  1  SHALL discard all held entries when high.
REQ-005 Port in_valid  input  1  SHALL indicate in_instr/in_pc are valid from fetch.
REQ-006 Port in_ready  output  1  SHALL indicate the queue accepts a write this cycle.
REQ-007 Port in_instr  input  16 (lc3b_word)  SHALL be the fetched instruction word.
REQ-008 Port in_pc  input  16 (lc3b_word)  SHALL be the PC of the fetched instruction.
REQ-009 Port out_valid  output  1  SHALL indicate the head entry is valid.
REQ-010 Port out_ready  input  1  SHALL indicate decode consumes the head this cycle.
REQ-011 Port out_instr  output  16  SHALL be the head instruction word.
REQ-012 Port out_pc  output  16  SHALL be the head PC.
REQ-013 Ports opcode (4, lc3b_opcode), dest/src1/src2 (3 each), offset6 (6), offset9 (9), imm5 (5), imm_bool (1), offset11 (11), jsr_bool (1), imm4 (4), shift_bool (1), trapvect (8), all outputs, SHALL be the decoded fields of out_instr.
REQ-014 Port count  output  $clog2(DEPTH+1)  SHALL be the number of valid entries.

Function
REQ-015 Push SHALL occur on a rising edge when in_valid && in_ready && !flush; entry written at tail, tail advances.
REQ-016 Pop SHALL occur on a rising edge when out_valid && out_ready && !flush; head advances.
REQ-017 in_ready SHALL equal (count < DEPTH); full queue does not accept a push even when a pop occurs in the same cycle.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-021 Push only: count +1; pop only: count -1; neither: count held.
REQ-022 A pushed entry SHALL appear on the outputs no earlier than the cycle after the push edge (no combinational in-to-out bypass); latency into an empty queue is exactly 1 cycle.
REQ-023 in_valid while in_ready=0 SHALL be ignored; fetch holds data until accepted.
REQ-024 flush SHALL, on the next edge, set count, head and tail to 0 and drop any same-cycle push and pop; flush has priority over both.
REQ-025 Field decode SHALL be combinational from out_instr: opcode=[15:12], dest=[11:9], src1=[8:6], src2=[2:0], offset6=[5:0], offset9=[8:0], imm5=[4:0], imm_bool=[5], offset11=[10:0], jsr_bool=[11], imm4=[3:0], shift_bool=[4], trapvect=[7:0].
REQ-026 When out_valid=0, out_instr and out_pc SHALL be 16'h0000, so all decoded fields are 0 (opcode = BR, all zero).
REQ-027 Storage array SHALL NOT require reset; only pointers and count are reset.

Reset
REQ-028 reset_n=0 at a rising edge SHALL set count=0, head=0, tail=0; then out_valid=0, in_ready=1, out_instr=0, out_pc=0, all fields 0.
REQ-029 Reset SHALL take priority over flush, push and pop; reset mid-operation discards all entries.
REQ-030 Entries pushed before reset SHALL never reappear on the outputs after reset.

Verification
REQ-031 Reset, then push 16'h1042 at pc 16'h3000 -> next cycle out_valid=1, opcode=4'h1, dest=0, src1=1, imm_bool=0, src2=2, out_pc=16'h3000, count=1.
REQ-032 DEPTH=4: push 4 entries, no pop -> count=4, in_ready=0; a 5th in_valid is not accepted; pop 4 -> entries emerge in push order and out_valid=0.
REQ-033 Steady streaming with in_valid=out_ready=1 for 3*DEPTH cycles -> count constant, pointers wrap, order preserved, no loss or duplication.
REQ-034 count=3, assert flush with push and pop -> next cycle count=0, out_valid=0, fields 0, pushed word absent.
REQ-035 Push 16'hF025 (TRAP x25), pop it -> trapvect=8'h25, opcode=4'hF while at head; after pop with queue empty all outputs 0.
REQ-036 count=2, assert reset_n=0 for one cycle alongside push -> count=0, in_ready=1, out_valid=0; following push delivered with 1-cycle latency.
